// File: rtl/io_uart_timer_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : io_uart_timer_bridge (+ io_uart_timer_bridge_fifo)          |
// | Description : Memory-mapped console UART (8N1, TX/RX byte FIFOs) and a    |
// |               32-bit free-running cycle timer behind the core I/O port.   |
// | Ports       : main_clk/reset        clock, async active-high reset        |
// |               address_out_io[31:0]  access address (window on [31:8])    |
// |               data_in_io[15:0]      write data                           |
// |               control_out_io[1:0]   00 idle, 01 read, 10 write, 11 ignored|
// |               data_out_io[15:0]     registered read data                 |
// |               uart_tx / uart_rx     serial out (idle high) / serial in    |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+

// Byte FIFO; i_push/i_pop arrive already qualified by the parent.
module io_uart_timer_bridge_fifo #(
    parameter int LOG2 = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_push,
    input  logic            i_pop,
    input  logic [7:0]      i_din,
    output logic [7:0]      o_dout,
    output logic [LOG2:0]   o_count
);
    localparam logic [LOG2-1:0] c_ptr_one = {{(LOG2-1){1'b0}}, 1'b1};
    localparam logic [LOG2:0]   c_cnt_one = {{LOG2{1'b0}}, 1'b1};

    logic [7:0]      r_mem [2**LOG2];
    logic [LOG2-1:0] r_wp;
    logic [LOG2-1:0] r_rp;
    logic [LOG2:0]   r_cnt;

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wp] <= i_din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_push) r_wp <= r_wp + c_ptr_one;
            if (i_pop)  r_rp <= r_rp + c_ptr_one;
            case ({i_push, i_pop})
                2'b10:   r_cnt <= r_cnt + c_cnt_one;
                2'b01:   r_cnt <= r_cnt - c_cnt_one;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign o_dout  = r_mem[r_rp];
    assign o_count = r_cnt;
endmodule

module io_uart_timer_bridge #(
    parameter logic [31:0] IO_BASE   = 32'hFFFF_FF00,
    parameter int          CLK_DIV   = 434,
    parameter int          FIFO_LOG2 = 4
) (
    input  logic        main_clk,
    input  logic        reset,
    input  logic [31:0] address_out_io,
    input  logic [15:0] data_in_io,
    input  logic [1:0]  control_out_io,
    output logic [15:0] data_out_io,
    output logic        uart_tx,
    input  logic        uart_rx
);
    localparam int                 c_div_w     = $clog2(CLK_DIV);
    localparam logic [c_div_w-1:0] c_bit_last  = c_div_w'(CLK_DIV - 1);
    localparam logic [c_div_w-1:0] c_half_last = c_div_w'(CLK_DIV / 2 - 1);
    localparam logic [c_div_w-1:0] c_div_one   = c_div_w'(1);
    localparam logic [FIFO_LOG2:0] c_fifo_full = {1'b1, {FIFO_LOG2{1'b0}}};

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_start = 2'd1;
    localparam logic [1:0] c_st_data  = 2'd2;
    localparam logic [1:0] c_st_stop  = 2'd3;

    // ---------------- bus decode ----------------
    logic       w_rd, w_wr, w_hit;
    logic [7:0] w_off;
    logic       w_unused_bits;
    assign w_hit = (address_out_io[31:8] == IO_BASE[31:8]);
    assign w_rd  = w_hit && (control_out_io == 2'b01);
    assign w_wr  = w_hit && (control_out_io == 2'b10);
    assign w_off = address_out_io[7:0];
    assign w_unused_bits = &{1'b0, data_in_io[15:8]};

    // ---------------- FIFOs ----------------
    logic [7:0]         w_tx_dout, w_rx_dout;
    logic [FIFO_LOG2:0] w_tx_count, w_rx_count;
    logic               w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
    logic               w_tx_pop, w_tx_push_req, w_tx_push;
    logic               w_rx_pop, w_rx_push_req, w_rx_push;
    logic [7:0]         r_rx_sh;

    assign w_tx_full  = (w_tx_count == c_fifo_full);
    assign w_tx_empty = (w_tx_count == '0);
    assign w_rx_full  = (w_rx_count == c_fifo_full);
    assign w_rx_empty = (w_rx_count == '0);

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign w_tx_push_req = w_wr && (w_off == 8'h00);
    assign w_tx_push     = w_tx_push_req && (!w_tx_full || w_tx_pop);
    assign w_rx_pop      = w_rd && (w_off == 8'h00) && !w_rx_empty;
    assign w_rx_push     = w_rx_push_req && (!w_rx_full || w_rx_pop);

    io_uart_timer_bridge_fifo #(.LOG2(FIFO_LOG2)) u_tx_fifo (
        .clk(main_clk), .rst(reset), .i_push(w_tx_push), .i_pop(w_tx_pop),
        .i_din(data_in_io[7:0]), .o_dout(w_tx_dout), .o_count(w_tx_count)
    );
    io_uart_timer_bridge_fifo #(.LOG2(FIFO_LOG2)) u_rx_fifo (
        .clk(main_clk), .rst(reset), .i_push(w_rx_push), .i_pop(w_rx_pop),
        .i_din(r_rx_sh), .o_dout(w_rx_dout), .o_count(w_rx_count)
    );

    // ---------------- TX shifter ----------------
    logic [1:0]         r_tx_state, w_tx_state_n;
    logic [c_div_w-1:0] r_tx_div, w_tx_div_n;
    logic [2:0]         r_tx_bit, w_tx_bit_n;
    logic [7:0]         r_tx_sh, w_tx_sh_n;
    logic               r_tx_line, w_tx_line_n;

    always_ff @(posedge main_clk or posedge reset) begin
        if (reset) begin
            r_tx_state <= c_st_idle;
            r_tx_div   <= '0;
            r_tx_bit   <= '0;
            r_tx_sh    <= '0;
            r_tx_line  <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_n;
            r_tx_div   <= w_tx_div_n;
            r_tx_bit   <= w_tx_bit_n;
            r_tx_sh    <= w_tx_sh_n;
            r_tx_line  <= w_tx_line_n;
        end
    end

    always_comb begin
        w_tx_state_n = r_tx_state;
        w_tx_div_n   = r_tx_div + c_div_one;
        w_tx_bit_n   = r_tx_bit;
        w_tx_sh_n    = r_tx_sh;
        w_tx_line_n  = r_tx_line;
        w_tx_pop     = 1'b0;
        case (r_tx_state)
            c_st_idle: begin
                w_tx_div_n = '0;
                if (!w_tx_empty) begin
                    w_tx_pop     = 1'b1;
                    w_tx_sh_n    = w_tx_dout;
                    w_tx_line_n  = 1'b0;
                    w_tx_state_n = c_st_start;
                end
            end
            c_st_start: begin
                if (r_tx_div == c_bit_last) begin
                    w_tx_div_n   = '0;
                    w_tx_bit_n   = '0;
                    w_tx_line_n  = r_tx_sh[0];
                    w_tx_state_n = c_st_data;
                end
            end
            c_st_data: begin
                if (r_tx_div == c_bit_last) begin
                    w_tx_div_n = '0;
                    if (r_tx_bit == 3'd7) begin
                        w_tx_line_n  = 1'b1;
                        w_tx_state_n = c_st_stop;
                    end else begin
                        w_tx_sh_n   = {1'b0, r_tx_sh[7:1]};
                        w_tx_line_n = r_tx_sh[1];
                        w_tx_bit_n  = r_tx_bit + 3'd1;
                    end
                end
            end
            default: begin
                // Stop bit; chain straight into the next start bit if data waits.
                if (r_tx_div == c_bit_last) begin
                    w_tx_div_n = '0;
                    if (!w_tx_empty) begin
                        w_tx_pop     = 1'b1;
                        w_tx_sh_n    = w_tx_dout;
                        w_tx_line_n  = 1'b0;
                        w_tx_state_n = c_st_start;
                    end else begin
                        w_tx_state_n = c_st_idle;
                    end
                end
            end
        endcase
    end

    assign uart_tx = r_tx_line;

    // ---------------- RX deserialiser ----------------
    logic               r_rx_s1, r_rx_s2, r_rx_d;
    logic [1:0]         r_rx_state, w_rx_state_n;
    logic [c_div_w-1:0] r_rx_div, w_rx_div_n;
    logic [2:0]         r_rx_bit, w_rx_bit_n;
    logic [7:0]         w_rx_sh_n;
    logic               w_rx_ferr;

    always_ff @(posedge main_clk or posedge reset) begin
        if (reset) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_d     <= 1'b1;
            r_rx_state <= c_st_idle;
            r_rx_div   <= '0;
            r_rx_bit   <= '0;
            r_rx_sh    <= '0;
        end else begin
            r_rx_s1    <= uart_rx;
            r_rx_s2    <= r_rx_s1;
            r_rx_d     <= r_rx_s2;
            r_rx_state <= w_rx_state_n;
            r_rx_div   <= w_rx_div_n;
            r_rx_bit   <= w_rx_bit_n;
            r_rx_sh    <= w_rx_sh_n;
        end
    end

    always_comb begin
        w_rx_state_n  = r_rx_state;
        w_rx_div_n    = r_rx_div + c_div_one;
        w_rx_bit_n    = r_rx_bit;
        w_rx_sh_n     = r_rx_sh;
        w_rx_push_req = 1'b0;
        w_rx_ferr     = 1'b0;
        case (r_rx_state)
            c_st_idle: begin
                // The detect cycle is already one cycle into the start bit.
                w_rx_div_n = c_div_one;
                if (r_rx_d && !r_rx_s2) w_rx_state_n = c_st_start;
            end
            c_st_start: begin
                if (r_rx_div == c_half_last) begin
                    w_rx_div_n = '0;
                    w_rx_bit_n = '0;
                    w_rx_state_n = r_rx_s2 ? c_st_idle : c_st_data;
                end
            end
            c_st_data: begin
                if (r_rx_div == c_bit_last) begin
                    w_rx_div_n = '0;
                    w_rx_sh_n  = {r_rx_s2, r_rx_sh[7:1]};
                    if (r_rx_bit == 3'd7) w_rx_state_n = c_st_stop;
                    else                  w_rx_bit_n   = r_rx_bit + 3'd1;
                end
            end
            default: begin
                if (r_rx_div == c_bit_last) begin
                    w_rx_div_n    = '0;
                    w_rx_state_n  = c_st_idle;
                    w_rx_push_req = r_rx_s2;
                    w_rx_ferr     = !r_rx_s2;
                end
            end
        endcase
    end

    // ---------------- registers, flags, timer ----------------
    logic        r_rx_ovf, r_tx_ovf, r_ferr;
    logic [31:0] r_timer;
    logic [15:0] r_shadow, r_dout;
    logic [15:0] w_status, w_rdata;
    logic        w_w1c;

    assign w_w1c = w_wr && (w_off == 8'h02);

    always_comb begin
        w_status    = '0;
        w_status[0] = !w_rx_empty;
        w_status[1] = w_tx_full;
        w_status[2] = w_tx_empty && (r_tx_state == c_st_idle);
        w_status[3] = r_rx_ovf;
        w_status[4] = r_tx_ovf;
        w_status[5] = r_ferr;
        w_status[8 +: FIFO_LOG2+1] = w_rx_count;
    end

    always_comb begin
        w_rdata = '0;
        case (w_off)
            8'h00:   if (!w_rx_empty) w_rdata = {1'b1, 7'b0, w_rx_dout};
            8'h02:   w_rdata = w_status;
            8'h04:   w_rdata = r_timer[15:0];
            8'h06:   w_rdata = r_shadow;
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge main_clk or posedge reset) begin
        if (reset) begin
            r_rx_ovf <= 1'b0;
            r_tx_ovf <= 1'b0;
            r_ferr   <= 1'b0;
            r_timer  <= '0;
            r_shadow <= '0;
            r_dout   <= '0;
        end else begin
            // A new event in the same cycle as a clear wins.
            r_rx_ovf <= (w_rx_push_req && w_rx_full && !w_rx_pop) ||
                        (r_rx_ovf && !(w_w1c && data_in_io[3]));
            r_tx_ovf <= (w_tx_push_req && w_tx_full && !w_tx_pop) ||
                        (r_tx_ovf && !(w_w1c && data_in_io[4]));
            r_ferr   <= w_rx_ferr || (r_ferr && !(w_w1c && data_in_io[5]));
            r_timer  <= r_timer + 32'd1;
            if (w_rd) begin
                r_dout <= w_rdata;
                if (w_off == 8'h04) r_shadow <= r_timer[31:16];
            end
        end
    end

    assign data_out_io = r_dout;
endmodule
`default_nettype wire

// File: tb/tb_io_uart_timer_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_io_uart_timer_bridge                                    |
// | Description : Directed self-checking bench for io_uart_timer_bridge,     |
// |               CLK_DIV=8, FIFO depth 16.                                  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_io_uart_timer_bridge;
    localparam int          CLK_DIV  = 8;
    localparam logic [31:0] c_data   = 32'hFFFF_FF00;
    localparam logic [31:0] c_status = 32'hFFFF_FF02;
    localparam logic [31:0] c_tlo    = 32'hFFFF_FF04;
    localparam logic [31:0] c_thi    = 32'hFFFF_FF06;

    logic        main_clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] address_out_io = '0;
    logic [15:0] data_in_io = '0;
    logic [1:0]  control_out_io = 2'b00;
    logic [15:0] data_out_io;
    logic        uart_tx;
    logic        uart_rx = 1'b1;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    io_uart_timer_bridge #(
        .IO_BASE(32'hFFFF_FF00), .CLK_DIV(CLK_DIV), .FIFO_LOG2(4)
    ) dut (
        .main_clk(main_clk), .reset(reset), .address_out_io(address_out_io),
        .data_in_io(data_in_io), .control_out_io(control_out_io),
        .data_out_io(data_out_io), .uart_tx(uart_tx), .uart_rx(uart_rx)
    );

    always #5 main_clk = ~main_clk;

    // Edges since reset release; equals the timer value while it is untouched.
    always @(posedge main_clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // All bus tasks start and end on a falling clock edge.
    task automatic bus_read(input logic [31:0] addr, output logic [15:0] d);
        address_out_io = addr;
        control_out_io = 2'b01;
        @(negedge main_clk);
        control_out_io = 2'b00;
        d = data_out_io;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [15:0] wd);
        address_out_io = addr;
        data_in_io     = wd;
        control_out_io = 2'b10;
        @(negedge main_clk);
        control_out_io = 2'b00;
    endtask

    task automatic rd_check(input logic [31:0] addr, input logic [15:0] exp, input string tag);
        logic [15:0] d;
        bus_read(addr, d);
        check(tag, d, exp);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        repeat (CLK_DIV) @(negedge main_clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CLK_DIV) @(negedge main_clk);
        end
        uart_rx = stop_bit;
        repeat (CLK_DIV) @(negedge main_clk);
        uart_rx = 1'b1;
        repeat (4) @(negedge main_clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] d;
        logic [15:0] exp_t;
        logic [9:0]  frame;

        // ---- reset ----
        #1 reset = 1'b1;
        repeat (3) @(negedge main_clk);
        check("reset_dout", data_out_io, 16'h0000);
        check("reset_tx", {15'b0, uart_tx}, 16'h0001);
        reset = 1'b0;
        @(negedge main_clk);
        rd_check(c_status, 16'h0004, "status_after_reset");

        // ---- timer snapshot ----
        repeat (5) @(negedge main_clk);
        exp_t = cyc[15:0];
        rd_check(c_tlo, exp_t, "timer_lo_k");
        rd_check(c_thi, 16'h0000, "timer_hi_k");
        exp_t = cyc[15:0];
        rd_check(c_tlo, exp_t, "timer_lo_k2");

        // ---- TX one frame: 0xA5 ----
        frame = {1'b1, 8'hA5, 1'b0};
        bus_write(c_data, 16'h00A5);
        check("tx_idle_at_e0", {15'b0, uart_tx}, 16'h0001);
        @(negedge main_clk);
        check("tx_start_edge", {15'b0, uart_tx}, 16'h0000);
        repeat (4) @(negedge main_clk);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("tx_bit%0d", i), {15'b0, uart_tx}, {15'b0, frame[i]});
            if (i < 9) repeat (CLK_DIV) @(negedge main_clk);
        end
        repeat (2) @(negedge main_clk);
        rd_check(c_status, 16'h0000, "tx_busy_e80");
        rd_check(c_status, 16'h0000, "tx_busy_e81");
        rd_check(c_status, 16'h0004, "tx_idle_e82");

        // ---- RX one frame: 0x3C ----
        send_rx(8'h3C, 1'b1);
        rd_check(c_data, 16'h803C, "rx_data_3c");
        rd_check(32'h0000_0000, 16'h803C, "out_of_window_hold");
        rd_check(c_data, 16'h0000, "rx_empty_read");
        bus_write(32'h1234_5600, 16'h0055);
        rd_check(c_status, 16'h0004, "out_of_window_write");

        // ---- RX framing error and W1C ----
        send_rx(8'h55, 1'b0);
        rd_check(c_status, 16'h0024, "frame_error_set");
        bus_write(c_status, 16'h0020);
        rd_check(c_status, 16'h0004, "frame_error_clr");

        // ---- RX glitch ----
        uart_rx = 1'b0;
        repeat (2) @(negedge main_clk);
        uart_rx = 1'b1;
        repeat (2 * CLK_DIV) @(negedge main_clk);
        rd_check(c_status, 16'h0004, "rx_glitch");

        // ---- RX overflow: 17 frames into a 16-deep FIFO ----
        for (int i = 1; i <= 17; i++) send_rx(8'(i), 1'b1);
        rd_check(c_status, 16'h100D, "rx_overflow_status");
        rd_check(c_data, 16'h8001, "rx_first_byte");
        rd_check(c_status, 16'h0F0D, "rx_count_after_pop");
        bus_write(c_status, 16'h0008);
        rd_check(c_status, 16'h0F05, "rx_ovf_clr");

        // ---- timer wrap ----
        force dut.r_timer = 32'hFFFF_FFFF;
        @(negedge main_clk);
        release dut.r_timer;
        rd_check(c_tlo, 16'hFFFF, "wrap_lo_max");
        rd_check(c_thi, 16'hFFFF, "wrap_hi_max");
        rd_check(c_tlo, 16'h0001, "wrap_lo_after");
        rd_check(c_thi, 16'h0000, "wrap_hi_after");

        // ---- TX overflow with the shifter busy, then reset mid-frame ----
        bus_write(c_data, 16'h00A5);
        for (int i = 0; i < 17; i++) bus_write(c_data, 16'(i));
        rd_check(c_status, 16'h0F13, "tx_full_overflow");
        repeat (19) @(negedge main_clk);
        check("tx_data_bit3", {15'b0, uart_tx}, 16'h0000);
        reset = 1'b1;
        #1;
        check("tx_async_reset", {15'b0, uart_tx}, 16'h0001);
        check("dout_async_reset", data_out_io, 16'h0000);
        repeat (2) @(negedge main_clk);
        reset = 1'b0;
        @(negedge main_clk);
        rd_check(c_status, 16'h0004, "status_after_midframe_reset");
        rd_check(c_data, 16'h0000, "rx_empty_after_reset");
        repeat (CLK_DIV) @(negedge main_clk);
        check("tx_idle_after_reset", {15'b0, uart_tx}, 16'h0001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/io_uart_timer_bridge.md
# io_uart_timer_bridge

Memory-mapped I/O peripheral placed directly downstream of the core's I/O port: it consumes the core's `address_out_io` / `control_out_io` / `data_in_io` strobes and drives `data_out_io` back.
- It provides a buffered 8N1 UART (TX and RX FIFOs) plus a 32-bit free-running cycle timer, which together give software console I/O and timekeeping.
- All register side effects happen exactly once per access strobe.

## Interface
- `IO_BASE`, default 32'hFFFF_FF00: window base; a request decodes when `address_out_io[31:8]==IO_BASE[31:8]`.
- `CLK_DIV`, default 434: UART bit period in `main_clk` cycles; must be ≥4.
- `FIFO_LOG2`, default 4: each FIFO holds 2^FIFO_LOG2 bytes.
- Ports:
  - `main_clk` in 1: single clock, rising edge.
  - `reset` in 1: asynchronous, active-high.
  - `address_out_io` in 32: access address from core.
  - `data_in_io` in 16: write data from core.
  - `control_out_io` in 2: strobe, valid one cycle per access. 2'b00 idle, 2'b01 read, 2'b10 write, 2'b11 reserved (ignored).
  - `data_out_io` out 16: registered read data to core.
  - `uart_tx` out 1: serial out, idle high.
  - `uart_rx` in 1: serial in, asynchronous.

## Operation
- Register offsets (`address_out_io[7:0]`); all other offsets read 0 and ignore writes:
  - 0x00 DATA. Write pushes `data_in_io[7:0]` to TX FIFO. Read returns `{rx_nonempty,7'b0,byte}` and pops RX. When RX is empty, a read returns 16'h0000 and does not pop.
  - 0x02 STATUS. Read fields: [0] rx_nonempty, [1] tx_full, [2] tx_idle (FIFO empty and shifter idle), [3] rx_overflow, [4] tx_overflow, [5] frame_error, [8+:FIFO_LOG2+1] RX count, other bits 0. Write is write-1-to-clear on bits [5:3].
  - 0x04 TIMER_LO. Read returns timer[15:0] and latches timer[31:16] into a shadow register.
  - 0x06 TIMER_HI. Read returns the shadow register.
- TX FIFO full on write: byte dropped, tx_overflow set (sticky).
- RX FIFO full on receive: byte dropped, rx_overflow set (sticky).
- Same-cycle push+pop on a full FIFO: both succeed, no overflow. Same-cycle push+pop on an empty FIFO: the read sees empty, and the pushed byte stays in the FIFO.
- TX FSM states IDLE→START→DATA(8 bits, LSB first)→STOP→IDLE. Each bit lasts CLK_DIV cycles. In IDLE with the FIFO non-empty, it pops the FIFO and enters START.
- RX path: 2-flop synchronizer on `uart_rx`. The FSM is IDLE→START→DATA→STOP.
  - A falling edge in IDLE starts START. The line is re-sampled at CLK_DIV/2; if it is high, the FSM aborts to IDLE (glitch).
  - The 8 data bits and the stop bit are sampled at mid-bit.
  - If the stop bit is low, frame_error is set, the byte is discarded, and the FSM returns to IDLE.
- Timer: 32-bit counter, +1 every cycle, wraps 32'hFFFF_FFFF→0.
- Requests outside the window: no side effect, and `data_out_io` holds its value.

## Timing
- Reset values:
  - `data_out_io`=0, `uart_tx`=1, timer=0, shadow=0.
  - FIFOs empty, all sticky flags 0, both FSMs IDLE.
  - Reset asserted mid-frame aborts the frame immediately; `uart_tx` goes high asynchronously.
- Read latency: a strobe sampled at edge E0 puts data on `data_out_io` after E0. The value holds until the next in-window read.
- Pop, push, W1C, and shadow latch all take effect at E0. STATUS read at E0+1 reflects them.
- TX start: a write at E0 into an empty FIFO with the shifter idle causes a pop at E1, and `uart_tx` falls after E1. Frame length is 10·CLK_DIV cycles. tx_idle reads 1 from the edge that ends the stop bit.
- RX: a byte becomes visible (rx_nonempty=1) at the edge ending the stop-bit sample, which is ≤ 2 + 9.5·CLK_DIV cycles after the falling edge on the pin.
- Back-to-back frames: the next start bit follows the previous stop bit with zero idle cycles when the FIFO is non-empty.

## Test plan
- Reset, then read STATUS → 16'h0004.
  - Read TIMER_LO at cycle k, then TIMER_HI → values consistent with count k, and HI equals the latched upper half.
- CLK_DIV=8: write 0x00←16'h00A5.
  - Expected `uart_tx` sequence: 0, 1,0,1,0,0,1,0,1, 1, with 8 cycles per bit and the start bit beginning 2 edges after the strobe.
  - tx_idle returns to 1 after 80 cycles.
- Drive an RX frame 0x3C, then read DATA → 16'h803C.
  - Read DATA again → 16'h0000.
  - An RX frame with stop bit=0 → STATUS[5]=1 and RX count 0; writing 0x02←16'h0020 clears it.
- Write 17 bytes to TX with depth 16 and the shifter stalled → tx_full=1 and tx_overflow=1.
  - Receive 17 RX bytes without reading → rx_overflow=1, count=16, and the first byte read is the first byte received.
- A 0.3·CLK_DIV low glitch on `uart_rx` → no byte received and no error flag.
  - Force the timer to 32'hFFFF_FFFF → it wraps to 0 on the next cycle.
- Assert `reset` during DATA bit 3 of TX → `uart_tx`=1 immediately, FIFOs empty, STATUS=16'h0004 after reset is released.
